// File: rtl/roic_frame_capture_if.sv
// roic_frame_capture_if: pixel stream channel carrying one raster beat per accepted transfer
interface roic_frame_capture_if #(
  parameter int DW = 12
);
  logic [DW-1:0] data;
  logic          valid;
  logic          ready;
  logic          sof;
  logic          eof;
  logic [1:0]    row;
  logic [1:0]    col;
  modport master(output data, valid, sof, eof, row, col, input ready);
  modport slave(input data, valid, sof, eof, row, col, output ready);
endinterface

// File: rtl/roic_frame_capture.sv
// roic_frame_capture: samples a 3x3 ROIC scan into ping-pong banks and streams each frame in raster order
module roic_frame_capture #(
  parameter int DW      = 12,
  parameter int ADC_LAT = 2,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 master_rst,
  input  logic                 fsync,
  input  logic                 intg,
  input  logic [2:0]           row,
  input  logic [2:0]           col,
  input  logic [DW-1:0]        adc_data,
  roic_frame_capture_if.master pix,
  output logic                 frame_err,
  output logic                 overrun,
  output logic [CNT_W-1:0]     drop_count
);
  typedef enum logic {WAIT_FSYNC, CAPTURE} cap_t;
  typedef enum logic {OUT_IDLE, OUT_STREAM} out_t;
  cap_t cs, cn;
  out_t os, on;
  logic [2:0] col_q;
  logic intg_q, pend, pend_n, wb;
  logic [ADC_LAT:0] q_v;
  logic [3:0] q_idx [ADC_LAT+1];
  logic [8:0] mask, mask_n;
  logic [DW-1:0] mem [2][9];
  logic [3:0] oidx, oidx_n, lidx, eidx;
  logic [1:0] rb, cb, orow;
  logic bad, strobe, ev, busy, fall, we, err, eval, rd_free, swap, ovr, acc;
  assign rb = {row[2], row[1]};
  assign cb = {col[2], col[1]};
  assign lidx = {2'b0, rb} + {1'b0, rb, 1'b0} + {2'b0, cb};
  assign bad = |col && !($onehot(row) && $onehot(col));
  assign strobe = cs == CAPTURE && |col && ~|col_q && !bad;
  // q_v[0] is a constant pad so the pipe still exists when ADC_LAT is 0
  assign ev = ADC_LAT == 0 ? strobe : q_v[ADC_LAT];
  assign eidx = ADC_LAT == 0 ? lidx : q_idx[ADC_LAT];
  assign busy = strobe || |q_v;
  assign fall = intg_q && !intg;
  assign acc = pix.valid && pix.ready;
  assign rd_free = os == OUT_IDLE || (acc && oidx == 4'd8);
  assign swap = eval && mask == 9'h1FF && rd_free;
  assign ovr = eval && mask == 9'h1FF && !rd_free;
  // strobe edge detect and ADC latency pipe carrying the target pixel index
  always_ff @(posedge clk or posedge master_rst)
    if (master_rst) begin
      col_q <= '0;
      intg_q <= 1'b0;
      q_v <= '0;
      for (int k = 0; k <= ADC_LAT; k++) q_idx[k] <= '0;
    end else begin
      col_q <= col;
      intg_q <= intg;
      q_v[0] <= 1'b0;
      q_idx[0] <= '0;
      for (int k = 1; k <= ADC_LAT; k++) begin
        q_v[k] <= k == 1 ? strobe : q_v[k-1];
        q_idx[k] <= k == 1 ? lidx : q_idx[k-1];
      end
    end
  // capture FSM: sample writes, fault detection, end-of-frame evaluation once the pipe drains
  always_comb begin
    cn = cs;
    mask_n = mask;
    pend_n = 1'b0;
    we = 1'b0;
    err = 1'b0;
    eval = 1'b0;
    if (cs == WAIT_FSYNC) begin
      if (fsync) begin
        cn = CAPTURE;
        mask_n = '0;
      end
    end else if (fsync) begin
      err = 1'b1;
      mask_n = '0;
    end else if (bad || (ev && mask[eidx])) begin
      err = 1'b1;
      cn = WAIT_FSYNC;
    end else begin
      if (ev) begin
        we = 1'b1;
        mask_n[eidx] = 1'b1;
      end
      pend_n = (fall || pend) && busy;
      if ((fall || pend) && !busy) begin
        eval = 1'b1;
        err = mask != 9'h1FF;
        cn = WAIT_FSYNC;
      end
    end
  end
  // output FSM: walk the read bank 0..8, advancing only on accepted beats
  always_comb begin
    on = os;
    oidx_n = oidx;
    if (swap) begin
      on = OUT_STREAM;
      oidx_n = '0;
    end else if (acc) begin
      on = oidx == 4'd8 ? OUT_IDLE : OUT_STREAM;
      oidx_n = oidx == 4'd8 ? 4'd0 : oidx + 4'd1;
    end
  end
  // state, bank pointer, fault pulses and saturating drop counter
  always_ff @(posedge clk or posedge master_rst)
    if (master_rst) begin
      cs <= WAIT_FSYNC;
      os <= OUT_IDLE;
      mask <= '0;
      pend <= 1'b0;
      oidx <= '0;
      wb <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
      drop_count <= '0;
    end else begin
      cs <= cn;
      os <= on;
      mask <= mask_n;
      pend <= pend_n;
      oidx <= oidx_n;
      frame_err <= err;
      overrun <= ovr;
      if (swap) wb <= ~wb;
      if (ovr && ~&drop_count) drop_count <= drop_count + 1'b1;
    end
  // ping-pong sample banks; wb selects the bank being filled
  always_ff @(posedge clk or posedge master_rst)
    if (master_rst) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < 9; i++) mem[b][i] <= '0;
    end else if (we) begin
      mem[wb][eidx] <= adc_data;
    end
  assign pix.valid = os == OUT_STREAM;
  assign orow = oidx >= 4'd6 ? 2'd2 : oidx >= 4'd3 ? 2'd1 : 2'd0;
  assign pix.row = pix.valid ? orow : 2'd0;
  assign pix.col = pix.valid ? 2'(oidx - 4'(3 * orow)) : 2'd0;
  assign pix.data = pix.valid ? mem[~wb][oidx] : '0;
  assign pix.sof = pix.valid && oidx == 4'd0;
  assign pix.eof = pix.valid && oidx == 4'd8;
endmodule
